// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
// Bundles the control inputs and timing outputs of vga_timing_gen.
//
// Signals
//   en         run enable (consumer -> generator)
//   irq_ack    vertical-blank interrupt acknowledge (consumer -> generator)
//   hsync      registered horizontal sync, polarity set by generator
//   vsync      registered vertical sync, polarity set by generator
//   video_on   current pixel lies in the display area
//   p_tick     pixel enable strobe
//   pixel_x    horizontal count  [CW-1:0]
//   pixel_y    vertical count    [CW-1:0]
//   sol, sof   start-of-line / start-of-frame strobes
//   frame_cnt  completed-frame count [FW-1:0]
//   irq_vblank sticky vertical-blank interrupt
//
// Modports
//   master : the timing generator side
//   slave  : the video consumer side
// ---------------------------------------------------------------------------
interface vga_timing_if #(
    parameter int CW = 10,
    parameter int FW = 8
);
    logic          en;
    logic          irq_ack;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          p_tick;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          sol;
    logic          sof;
    logic [FW-1:0] frame_cnt;
    logic          irq_vblank;

    modport master (
        input  en, irq_ack,
        output hsync, vsync, video_on, p_tick, pixel_x, pixel_y,
               sol, sof, frame_cnt, irq_vblank
    );

    modport slave (
        output en, irq_ack,
        input  hsync, vsync, video_on, p_tick, pixel_x, pixel_y,
               sol, sof, frame_cnt, irq_vblank
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Generic raster timing generator: pixel clock divider, horizontal and
// vertical counters, registered sync outputs, start-of-line/frame strobes,
// a completed-frame counter and an optional sticky vertical-blank interrupt.
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   vif    vga_timing_if.master (en, irq_ack in; timing outputs out)
//
// Configuration macro
//   VGA_TIMING_IRQ_EN  when defined, irq_vblank sets at the end of the last
//                      display line and clears on irq_ack (set wins).
//                      When undefined, irq_vblank is tied to 0, irq_ack is
//                      ignored and no interrupt flop exists.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int HD      = 640,
    parameter int HF      = 16,
    parameter int HR      = 96,
    parameter int HB      = 48,
    parameter int VD      = 480,
    parameter int VF      = 10,
    parameter int VR      = 2,
    parameter int VB      = 33,
    parameter int CLK_DIV = 2,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int CW      = 10,
    parameter int FW      = 8
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vif
);

    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_MAX    = CW'(HT - 1);
    localparam logic [CW-1:0] V_MAX    = CW'(VT - 1);
    localparam logic [CW-1:0] H_DISP   = CW'(HD);
    localparam logic [CW-1:0] V_DISP   = CW'(VD);
    localparam logic [CW-1:0] V_LAST   = CW'(VD - 1);
    localparam logic [CW-1:0] HS_FIRST = CW'(HD + HF);
    localparam logic [CW-1:0] HS_LAST  = CW'(HD + HF + HR - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(VD + VF);
    localparam logic [CW-1:0] VS_LAST  = CW'(VD + VF + VR - 1);
    localparam logic          HS_ON    = 1'(HS_POL);
    localparam logic          VS_ON    = 1'(VS_POL);

    logic [DW-1:0] div_q;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [FW-1:0] frame_q;
    logic          hs_p1;
    logic          vs_p1;
    logic          div_end;
    logic          tick;
    logic          h_end;
    logic          v_end;
    logic          hs_act;
    logic          vs_act;

    // ---- stage p0: divider, counters and decode (combinational) ----
    assign div_end = (div_q == DIV_MAX);
    // Gated by reset so the strobes are quiet while reset is held, even
    // with CLK_DIV=1 where the divider compare is always true.
    assign tick    = vif.en && div_end && !reset;
    assign h_end   = (h_cnt == H_MAX);
    assign v_end   = (v_cnt == V_MAX);
    assign hs_act  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vs_act  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (vif.en) begin
            div_q <= div_end ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            h_cnt <= h_end ? '0 : h_cnt + 1'b1;
            if (h_end) begin
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
        end else if (tick && h_end && v_end) begin
            frame_q <= frame_q + 1'b1;
        end
    end

    // ---- stage p1: registered syncs, one clk behind the counters ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_p1 <= ~HS_ON;
            vs_p1 <= ~VS_ON;
        end else if (vif.en) begin
            hs_p1 <= hs_act ? HS_ON : ~HS_ON;
            vs_p1 <= vs_act ? VS_ON : ~VS_ON;
        end
    end

`ifdef VGA_TIMING_IRQ_EN
    logic irq_q;

    // Set has priority so an ack landing on the set cycle cannot lose it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (tick && h_end && (v_cnt == V_LAST)) begin
            irq_q <= 1'b1;
        end else if (vif.irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    assign vif.irq_vblank = irq_q;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = vif.irq_ack;
    assign vif.irq_vblank = 1'b0;
`endif

    assign vif.p_tick    = tick;
    assign vif.pixel_x   = h_cnt;
    assign vif.pixel_y   = v_cnt;
    assign vif.video_on  = (h_cnt < H_DISP) && (v_cnt < V_DISP);
    assign vif.sol       = tick && (h_cnt == '0);
    assign vif.sof       = tick && (h_cnt == '0) && (v_cnt == '0);
    assign vif.frame_cnt = frame_q;
    assign vif.hsync     = hs_p1;
    assign vif.vsync     = vs_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Small raster: HT=16 (8/2/3/3), VT=8 (4/1/2/1).
// DUT A: CLK_DIV=2, active-low syncs.  DUT B: CLK_DIV=1, active-high syncs.
module tb_vga_timing_gen;

    localparam int CW = 6;
    localparam int FW = 3;
`ifdef VGA_TIMING_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vecs = 0;
    int   miss = 0;

    vga_timing_if #(.CW(CW), .FW(FW)) a_if ();
    vga_timing_if #(.CW(CW), .FW(FW)) b_if ();

    vga_timing_gen #(
        .HD(8), .HF(2), .HR(3), .HB(3), .VD(4), .VF(1), .VR(2), .VB(1),
        .CLK_DIV(2), .HS_POL(0), .VS_POL(0), .CW(CW), .FW(FW)
    ) dut_a (
        .clk(clk), .reset(reset), .vif(a_if)
    );

    vga_timing_gen #(
        .HD(8), .HF(2), .HR(3), .HB(3), .VD(4), .VF(1), .VR(2), .VB(1),
        .CLK_DIV(1), .HS_POL(1), .VS_POL(1), .CW(CW), .FW(FW)
    ) dut_b (
        .clk(clk), .reset(reset), .vif(b_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Bounded wait for a raster position; y<0 means any line.
    task automatic wait_pos(input bit sel, input int x, input int y, input bit tk,
                            input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (!sel && a_if.pixel_x == CW'(x) && (y < 0 || a_if.pixel_y == CW'(y))
                && a_if.p_tick == tk) begin
                ok = 1'b1;
                break;
            end
            if (sel && b_if.pixel_x == CW'(x) && (y < 0 || b_if.pixel_y == CW'(y))
                && b_if.p_tick == tk) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        vecs++;
        if (!ok) begin
            miss++;
            $display("FAIL %s: position x=%0d y=%0d not reached, got 0 want 1", name, x, y);
        end
    endtask

    task automatic test_reset();
        a_if.en = 1'b1; a_if.irq_ack = 1'b0;
        b_if.en = 1'b1; b_if.irq_ack = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        vecs++; if (a_if.pixel_x !== 6'd0) begin miss++; $display("FAIL rst_x: got %0d want 0", a_if.pixel_x); end
        vecs++; if (a_if.pixel_y !== 6'd0) begin miss++; $display("FAIL rst_y: got %0d want 0", a_if.pixel_y); end
        vecs++; if (a_if.p_tick !== 1'b0) begin miss++; $display("FAIL rst_ptick: got %b want 0", a_if.p_tick); end
        vecs++; if (a_if.sol !== 1'b0 || a_if.sof !== 1'b0) begin miss++; $display("FAIL rst_sol_sof: got %b%b want 00", a_if.sol, a_if.sof); end
        vecs++; if (a_if.frame_cnt !== 3'd0) begin miss++; $display("FAIL rst_frame: got %0d want 0", a_if.frame_cnt); end
        vecs++; if (a_if.hsync !== 1'b1 || a_if.vsync !== 1'b1) begin miss++; $display("FAIL rst_sync_a: got %b%b want 11", a_if.hsync, a_if.vsync); end
        vecs++; if (a_if.irq_vblank !== 1'b0) begin miss++; $display("FAIL rst_irq: got %b want 0", a_if.irq_vblank); end
        vecs++; if (a_if.video_on !== 1'b1) begin miss++; $display("FAIL rst_video_on: got %b want 1", a_if.video_on); end
        vecs++; if (b_if.hsync !== 1'b0 || b_if.vsync !== 1'b0) begin miss++; $display("FAIL rst_sync_b: got %b%b want 00", b_if.hsync, b_if.vsync); end
        vecs++; if (b_if.p_tick !== 1'b0) begin miss++; $display("FAIL rst_ptick_b: got %b want 0", b_if.p_tick); end
        reset = 1'b0;
        #1;
        vecs++; if (a_if.p_tick !== 1'b0) begin miss++; $display("FAIL rel_ptick_a: got %b want 0", a_if.p_tick); end
        vecs++; if (b_if.p_tick !== 1'b1) begin miss++; $display("FAIL rel_ptick_b: got %b want 1", b_if.p_tick); end
        step();
        vecs++; if (a_if.sof !== 1'b1 || a_if.p_tick !== 1'b1) begin miss++; $display("FAIL first_sof: got sof=%b tick=%b want 1 1", a_if.sof, a_if.p_tick); end
        vecs++; if (b_if.pixel_x !== 6'd1) begin miss++; $display("FAIL b_first_adv: got %0d want 1", b_if.pixel_x); end
    endtask

    // Starts on a sof cycle; measures one full frame up to the next sof.
    task automatic test_line_frame();
        int clks = 0, pt = 0, sl = 0, first_sol = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            clks++;
            pt += int'(a_if.p_tick);
            sl += int'(a_if.sol);
            if (a_if.sol && first_sol == 0) first_sol = clks;
            if (a_if.sof) break;
        end
        vecs++; if (clks != 256) begin miss++; $display("FAIL sof_period: got %0d want 256", clks); end
        vecs++; if (pt != 128) begin miss++; $display("FAIL ticks_per_frame: got %0d want 128", pt); end
        vecs++; if (sl != 8) begin miss++; $display("FAIL lines_per_frame: got %0d want 8", sl); end
        vecs++; if (first_sol != 32) begin miss++; $display("FAIL line_period: got %0d want 32", first_sol); end
        vecs++; if (a_if.frame_cnt !== 3'd1) begin miss++; $display("FAIL frame_after_1: got %0d want 1", a_if.frame_cnt); end
    endtask

    task automatic test_video();
        wait_pos(0, 7, 0, 0, "wait_x7");
        vecs++; if (a_if.video_on !== 1'b1) begin miss++; $display("FAIL video_x7: got %b want 1", a_if.video_on); end
        wait_pos(0, 8, 0, 0, "wait_x8");
        vecs++; if (a_if.video_on !== 1'b0) begin miss++; $display("FAIL video_x8: got %b want 0", a_if.video_on); end
        wait_pos(0, 0, 4, 0, "wait_y4");
        vecs++; if (a_if.video_on !== 1'b0) begin miss++; $display("FAIL video_y4: got %b want 0", a_if.video_on); end
        wait_pos(0, 0, 3, 0, "wait_y3");
        vecs++; if (a_if.video_on !== 1'b1) begin miss++; $display("FAIL video_y3: got %b want 1", a_if.video_on); end
    endtask

    task automatic test_hsync();
        int n = 0;
        wait_pos(0, 10, -1, 0, "wait_hs");
        vecs++; if (a_if.hsync !== 1'b1) begin miss++; $display("FAIL hs_pre: got %b want 1", a_if.hsync); end
        step();
        for (int i = 0; i < 50; i++) begin
            if (a_if.hsync !== 1'b0) break;
            n++;
            step();
        end
        vecs++; if (n != 6) begin miss++; $display("FAIL hs_width: got %0d want 6", n); end
        vecs++; if (a_if.pixel_x !== 6'd13) begin miss++; $display("FAIL hs_end_x: got %0d want 13", a_if.pixel_x); end
    endtask

    task automatic test_vsync();
        int n = 0;
        wait_pos(0, 0, 5, 0, "wait_vs");
        vecs++; if (a_if.vsync !== 1'b1) begin miss++; $display("FAIL vs_pre: got %b want 1", a_if.vsync); end
        step();
        for (int i = 0; i < 200; i++) begin
            if (a_if.vsync !== 1'b0) break;
            n++;
            step();
        end
        vecs++; if (n != 64) begin miss++; $display("FAIL vs_width: got %0d want 64", n); end
        vecs++; if (a_if.pixel_y !== 6'd7 || a_if.pixel_x !== 6'd0) begin miss++; $display("FAIL vs_end: got y=%0d x=%0d want 7 0", a_if.pixel_y, a_if.pixel_x); end
    endtask

    task automatic test_polarity();
        int n = 0, bad = 0;
        wait_pos(1, 10, -1, 1, "wait_b_hs");
        vecs++; if (b_if.hsync !== 1'b0) begin miss++; $display("FAIL b_hs_pre: got %b want 0", b_if.hsync); end
        step();
        for (int i = 0; i < 50; i++) begin
            if (b_if.hsync !== 1'b1) break;
            if (b_if.p_tick !== 1'b1) bad++;
            n++;
            step();
        end
        vecs++; if (n != 3) begin miss++; $display("FAIL b_hs_width: got %0d want 3", n); end
        vecs++; if (b_if.pixel_x !== 6'd14) begin miss++; $display("FAIL b_hs_end_x: got %0d want 14", b_if.pixel_x); end
        for (int i = 0; i < 20; i++) begin
            if (b_if.p_tick !== 1'b1) bad++;
            step();
        end
        vecs++; if (bad != 0) begin miss++; $display("FAIL b_ptick_const: got %0d low cycles want 0", bad); end
        wait_pos(1, 0, 5, 1, "wait_b_vs");
        vecs++; if (b_if.vsync !== 1'b0) begin miss++; $display("FAIL b_vs_pre: got %b want 0", b_if.vsync); end
        step();
        vecs++; if (b_if.vsync !== 1'b1) begin miss++; $display("FAIL b_vs_on: got %b want 1", b_if.vsync); end
    endtask

    task automatic test_irq();
        a_if.irq_ack = 1'b1;
        step();
        a_if.irq_ack = 1'b0;
        #1;
        vecs++; if (a_if.irq_vblank !== 1'b0) begin miss++; $display("FAIL irq_clr0: got %b want 0", a_if.irq_vblank); end
        wait_pos(0, 15, 3, 1, "wait_irq_set");
        vecs++; if (a_if.irq_vblank !== 1'b0) begin miss++; $display("FAIL irq_pre: got %b want 0", a_if.irq_vblank); end
        step();
        vecs++; if (a_if.irq_vblank !== IRQ_ON) begin miss++; $display("FAIL irq_set: got %b want %b", a_if.irq_vblank, IRQ_ON); end
        vecs++; if (a_if.pixel_y !== 6'd4 || a_if.pixel_x !== 6'd0) begin miss++; $display("FAIL irq_pos: got y=%0d x=%0d want 4 0", a_if.pixel_y, a_if.pixel_x); end
        repeat (3) step();
        vecs++; if (a_if.irq_vblank !== IRQ_ON) begin miss++; $display("FAIL irq_sticky: got %b want %b", a_if.irq_vblank, IRQ_ON); end
        a_if.irq_ack = 1'b1;
        step();
        a_if.irq_ack = 1'b0;
        #1;
        vecs++; if (a_if.irq_vblank !== 1'b0) begin miss++; $display("FAIL irq_ack: got %b want 0", a_if.irq_vblank); end
        wait_pos(0, 15, 3, 1, "wait_irq_set2");
        a_if.irq_ack = 1'b1;
        step();
        a_if.irq_ack = 1'b0;
        #1;
        vecs++; if (a_if.irq_vblank !== IRQ_ON) begin miss++; $display("FAIL irq_set_vs_ack: got %b want %b", a_if.irq_vblank, IRQ_ON); end
        a_if.en = 1'b0;
        a_if.irq_ack = 1'b1;
        step();
        a_if.irq_ack = 1'b0;
        #1;
        vecs++; if (a_if.irq_vblank !== 1'b0) begin miss++; $display("FAIL irq_ack_en0: got %b want 0", a_if.irq_vblank); end
        a_if.en = 1'b1;
    endtask

    task automatic test_enable_hold();
        int bad = 0;
        wait_pos(0, 11, 1, 1, "wait_en");
        a_if.en = 1'b0;
        #1;
        vecs++; if (a_if.p_tick !== 1'b0) begin miss++; $display("FAIL en0_ptick: got %b want 0", a_if.p_tick); end
        for (int i = 0; i < 37; i++) begin
            step();
            if (a_if.pixel_x !== 6'd11 || a_if.pixel_y !== 6'd1 || a_if.hsync !== 1'b0
                || a_if.vsync !== 1'b1 || a_if.p_tick !== 1'b0 || a_if.sol !== 1'b0) bad++;
        end
        vecs++; if (bad != 0) begin miss++; $display("FAIL en0_hold: got %0d changed cycles want 0", bad); end
        a_if.en = 1'b1;
        #1;
        vecs++; if (a_if.p_tick !== 1'b1 || a_if.pixel_x !== 6'd11) begin miss++; $display("FAIL en_resume: got tick=%b x=%0d want 1 11", a_if.p_tick, a_if.pixel_x); end
        step();
        vecs++; if (a_if.pixel_x !== 6'd12 || a_if.p_tick !== 1'b0) begin miss++; $display("FAIL en_next: got x=%0d tick=%b want 12 0", a_if.pixel_x, a_if.p_tick); end
        vecs++; if (a_if.hsync !== 1'b0) begin miss++; $display("FAIL en_hs: got %b want 0", a_if.hsync); end
    endtask

    task automatic test_reset_midframe();
        wait_pos(0, 5, 2, 0, "wait_mid");
        reset = 1'b1;
        #1;
        vecs++; if (a_if.pixel_x !== 6'd0 || a_if.pixel_y !== 6'd0) begin miss++; $display("FAIL mid_xy: got %0d %0d want 0 0", a_if.pixel_x, a_if.pixel_y); end
        vecs++; if (a_if.p_tick !== 1'b0 || a_if.sol !== 1'b0 || a_if.sof !== 1'b0) begin miss++; $display("FAIL mid_strobes: got %b%b%b want 000", a_if.p_tick, a_if.sol, a_if.sof); end
        vecs++; if (a_if.hsync !== 1'b1 || a_if.vsync !== 1'b1) begin miss++; $display("FAIL mid_sync: got %b%b want 11", a_if.hsync, a_if.vsync); end
        vecs++; if (a_if.frame_cnt !== 3'd0 || a_if.irq_vblank !== 1'b0) begin miss++; $display("FAIL mid_frame_irq: got %0d %b want 0 0", a_if.frame_cnt, a_if.irq_vblank); end
        repeat (2) step();
        reset = 1'b0;
        #1;
        vecs++; if (a_if.sof !== 1'b0) begin miss++; $display("FAIL mid_rel_sof0: got %b want 0", a_if.sof); end
        step();
        vecs++; if (a_if.sof !== 1'b1) begin miss++; $display("FAIL mid_rel_sof1: got %b want 1", a_if.sof); end
        step();
        vecs++; if (a_if.pixel_x !== 6'd1 || a_if.sof !== 1'b0) begin miss++; $display("FAIL mid_rel_adv: got x=%0d sof=%b want 1 0", a_if.pixel_x, a_if.sof); end
    endtask

    task automatic test_frame_wrap();
        for (int f = 1; f <= 8; f++) begin
            wait_pos(0, 0, 0, 1, "wait_sof");
            vecs++;
            if (a_if.frame_cnt !== 3'(f)) begin
                miss++;
                $display("FAIL frame_wrap_%0d: got %0d want %0d", f, a_if.frame_cnt, f % 8);
            end
            step();
        end
    endtask

    initial begin
        a_if.en = 1'b0; a_if.irq_ack = 1'b0;
        b_if.en = 1'b0; b_if.irq_ack = 1'b0;
        test_reset();
        test_line_frame();
        test_video();
        test_hsync();
        test_vsync();
        test_polarity();
        test_irq();
        test_enable_hold();
        test_reset_midframe();
        test_frame_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
